quad_store_unit: RTL

- Store-side counterpart of the quad load path: accepts byte/word/long/quad store requests at byte addresses and commits them to the 64-bit quad RAM.
- Sub-quad stores use read-modify-write: read the containing quad, shift and merge the new bytes in, write the quad back.
- Sits between the CPU/loader store port and the single-port synchronous quad RAM (1-cycle read latency).

---
 rtl/pkg_ram.sv | 31 +++
 rtl/quad_lshift.sv | 35 +++
 rtl/quad_store_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pkg_ram.sv
`default_nettype none
// ============================================================================
// Module      : pkg_ram
// Description : Quad RAM geometry, store size codes and store-unit FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_ram;

    localparam int RAM_QUAD_SIZE = 64;

    typedef logic [1:0] ram_size_t;

    localparam ram_size_t RAM_BYTE = 2'd0;
    localparam ram_size_t RAM_WORD = 2'd1;
    localparam ram_size_t RAM_LONG = 2'd2;
    localparam ram_size_t RAM_QUAD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } store_state_t;

    function automatic logic [3:0] size_bytes(input ram_size_t size);
        return 4'd1 << size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_lshift.sv
`default_nettype none
// ============================================================================
// Module      : quad_lshift
// Description : Places right-aligned store data into its byte lanes of a quad.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_lshift
    import pkg_ram::*;
(
    input  logic [RAM_QUAD_SIZE-1:0] data,
    input  logic [2:0]               offset,
    input  ram_size_t                size,
    output logic [RAM_QUAD_SIZE-1:0] shifted,
    output logic [RAM_QUAD_SIZE-1:0] mask
);

    logic [RAM_QUAD_SIZE-1:0] size_mask;
    logic [5:0]               bit_shift;

    always_comb begin
        size_mask = '0;
        case (size)
            RAM_BYTE: size_mask = 64'h0000_0000_0000_00FF;
            RAM_WORD: size_mask = 64'h0000_0000_0000_FFFF;
            RAM_LONG: size_mask = 64'h0000_0000_FFFF_FFFF;
            default:  size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        bit_shift = {offset, 3'b000};
        mask      = size_mask << bit_shift;
        // Upper input bits are dropped before shifting so they never reach a lane.
        shifted   = (data & size_mask) << bit_shift;
    end

endmodule
`default_nettype wire

// File: rtl/quad_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : quad_store_unit
// Description : Commits byte/word/long/quad stores to the quad RAM (RMW below quad).
// Revision    : 1.0 - initial release
// ============================================================================
module quad_store_unit
    import pkg_ram::*;
#(
    parameter  int ADDR_WIDTH      = 16,
    localparam int QUAD_ADDR_WIDTH = ADDR_WIDTH - 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [1:0]                 req_size,
    input  logic [RAM_QUAD_SIZE-1:0]   req_data,
    output logic                       done,
    output logic                       err,
    output logic                       ram_en,
    output logic                       ram_we,
    output logic [QUAD_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_QUAD_SIZE-1:0]   ram_wdata,
    input  logic [RAM_QUAD_SIZE-1:0]   ram_rdata
);

    store_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    ram_size_t                size_q, size_d;
    logic [RAM_QUAD_SIZE-1:0] data_q, data_d;
    logic [RAM_QUAD_SIZE-1:0] merged_q, merged_d;

    logic [RAM_QUAD_SIZE-1:0] shifted;
    logic [RAM_QUAD_SIZE-1:0] lane_mask;
    logic [3:0]               req_bytes;
    logic [3:0]               align_mask;
    logic                     misaligned;

    quad_lshift u_lshift (
        .data    (data_q),
        .offset  (addr_q[2:0]),
        .size    (size_q),
        .shifted (shifted),
        .mask    (lane_mask)
    );

    always_comb begin
        req_bytes  = size_bytes(req_size);
        align_mask = req_bytes - 4'd1;
        misaligned = |({1'b0, req_addr[2:0]} & align_mask);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        data_d    = data_q;
        merged_d  = merged_q;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d = req_addr;
                    size_d = req_size;
                    data_d = req_data;
                    if (misaligned) begin
                        state_d = ST_ERR;
                    end else if (req_size == RAM_QUAD) begin
                        // Full quad needs no read: the store data is the write word.
                        merged_d = req_data;
                        state_d  = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                ram_en  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                merged_d = (ram_rdata & ~lane_mask) | (shifted & lane_mask);
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = merged_q;
                done      = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_addr = addr_q[ADDR_WIDTH-1:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= RAM_BYTE;
            data_q   <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            data_q   <= data_d;
            merged_q <= merged_d;
        end
    end

endmodule
`default_nettype wire
